// File: rtl/segment_loader_pkg.sv
// Shared constants for the segment loader and the clock-segment consumer.
// Record layout: on_counts[127:80], off_counts[79:32], repeat_counts[31:0].
package segment_loader_pkg;

  localparam int unsigned DEF_DATA_W        = 16;
  localparam int unsigned DEF_WORDS_PER_SEG = 8;
  localparam int unsigned DEF_SEG_W         = 128;
  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned EDGE_W            = 32;

  localparam int unsigned ON_MSB  = 127;
  localparam int unsigned ON_LSB  = 80;
  localparam int unsigned OFF_MSB = 79;
  localparam int unsigned OFF_LSB = 32;
  localparam int unsigned REP_MSB = 31;
  localparam int unsigned REP_LSB = 0;

  localparam int unsigned PST_W = 2;
  localparam logic [PST_W-1:0] P_EMPTY = 2'd0;
  localparam logic [PST_W-1:0] P_WRITE = 2'd1;
  localparam logic [PST_W-1:0] P_WAIT  = 2'd2;

  typedef struct packed {
    logic [ON_MSB-ON_LSB:0]   on_counts;
    logic [OFF_MSB-OFF_LSB:0] off_counts;
    logic [REP_MSB-REP_LSB:0] repeat_counts;
  } seg_rec_t;

  // Saturating add for the edge accumulator.
  function automatic logic [EDGE_W-1:0] sat_add_edges(input logic [EDGE_W-1:0] a,
                                                      input logic [EDGE_W-1:0] b);
    logic [EDGE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[EDGE_W] ? {EDGE_W{1'b1}} : s[EDGE_W-1:0];
  endfunction

endpackage

// File: rtl/seg_validate.sv
// Combinational record checker: retrigger records (rep==0) always pass,
// counted records need non-zero on and off phases.
module seg_validate
  import segment_loader_pkg::*;
#(
  parameter int unsigned SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] rec,
  output logic             is_retrigger,
  output logic             is_valid
);

  always_comb begin
    is_retrigger = (rec[REP_MSB:REP_LSB] == '0);
    is_valid     = is_retrigger ||
                   ((rec[ON_MSB:ON_LSB] != '0) && (rec[OFF_MSB:OFF_LSB] != '0));
  end

endmodule

// File: rtl/segment_loader.sv
// Packs pipe words into 128-bit segment records, validates them and feeds the
// segment FIFO through a one-entry pending register; keeps load statistics.
module segment_loader
  import segment_loader_pkg::*;
#(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned WORDS_PER_SEG = DEF_WORDS_PER_SEG,
  parameter int unsigned SEG_W         = DEF_SEG_W,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic              ti_clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              pipe_write,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              fifo_full,
  output logic [SEG_W-1:0]  fifo_din,
  output logic              fifo_wr_en,
  output logic [CNT_W-1:0]  seg_count,
  output logic [31:0]       expected_edges,
  output logic [CNT_W-1:0]  drop_count,
  output logic [CNT_W-1:0]  invalid_count,
  output logic              overflow,
  output logic              partial,
  output logic              busy
);

  localparam int unsigned IDX_W = (WORDS_PER_SEG > 1) ? $clog2(WORDS_PER_SEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_SEG - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [IDX_W-1:0] word_idx, word_idx_nxt;
  logic [SEG_W-1:0] shift_q, shift_nxt;
  logic [SEG_W-1:0] pend_q;
  logic             seg_done_c;
  logic             is_retrigger_c, is_valid_c;

  logic [PST_W-1:0] state, state_nxt;
  logic             load_c, wr_nxt_c, drop_c, inval_c;
  seg_rec_t         wr_rec_c;
  logic [31:0]      wr_rep_c;

  // Word assembly: MSB-first shift, completion on the last word of a record.
  always_comb begin
    word_idx_nxt = word_idx;
    shift_nxt    = shift_q;
    seg_done_c   = 1'b0;
    if (flush) begin
      word_idx_nxt = '0;
    end else if (pipe_write) begin
      shift_nxt = {shift_q[SEG_W-DATA_W-1:0], pipe_data};
      if (word_idx == LAST_IDX) begin
        word_idx_nxt = '0;
        seg_done_c   = 1'b1;
      end else begin
        word_idx_nxt = word_idx + IDX_W'(1);
      end
    end
  end

  seg_validate #(.SEG_W(SEG_W)) u_validate (
    .rec          (shift_nxt),
    .is_retrigger (is_retrigger_c),
    .is_valid     (is_valid_c)
  );

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) state <= P_EMPTY;
    else        state <= state_nxt;
  end

  // Pending-record FSM; a record completing while one is already waiting is dropped.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    drop_c    = 1'b0;
    inval_c   = 1'b0;
    if (flush) begin
      state_nxt = P_EMPTY;
    end else begin
      inval_c = seg_done_c && !is_valid_c;
      case (state)
        P_EMPTY, P_WRITE: begin
          if (seg_done_c && is_valid_c) begin
            load_c    = 1'b1;
            state_nxt = fifo_full ? P_WAIT : P_WRITE;
          end else begin
            state_nxt = P_EMPTY;
          end
        end
        P_WAIT: begin
          drop_c = seg_done_c && is_valid_c;
          if (!fifo_full) state_nxt = P_WRITE;
        end
        default: state_nxt = P_EMPTY;
      endcase
    end
    wr_nxt_c = (state_nxt == P_WRITE);
    wr_rec_c = seg_rec_t'(load_c ? shift_nxt : pend_q);
    wr_rep_c = (load_c && is_retrigger_c) ? 32'd0 : wr_rec_c.repeat_counts;
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx       <= '0;
      shift_q        <= '0;
      pend_q         <= '0;
      fifo_din       <= '0;
      fifo_wr_en     <= 1'b0;
      partial        <= 1'b0;
      busy           <= 1'b0;
      seg_count      <= '0;
      expected_edges <= '0;
      drop_count     <= '0;
      invalid_count  <= '0;
      overflow       <= 1'b0;
    end else begin
      word_idx   <= word_idx_nxt;
      shift_q    <= shift_nxt;
      fifo_wr_en <= wr_nxt_c;
      partial    <= (word_idx_nxt != '0);
      busy       <= (word_idx_nxt != '0) || (state_nxt != P_EMPTY);
      if (load_c)   pend_q   <= shift_nxt;
      if (wr_nxt_c) fifo_din <= SEG_W'(wr_rec_c);
      if (flush) begin
        seg_count      <= '0;
        expected_edges <= '0;
        drop_count     <= '0;
        invalid_count  <= '0;
        overflow       <= 1'b0;
      end else begin
        if (wr_nxt_c) begin
          seg_count      <= sat_inc(seg_count);
          expected_edges <= sat_add_edges(expected_edges, wr_rep_c);
        end
        if (drop_c) begin
          drop_count <= sat_inc(drop_count);
          overflow   <= 1'b1;
        end
        if (inval_c) invalid_count <= sat_inc(invalid_count);
      end
    end
  end

endmodule

// File: doc/segment_loader.md
Name: segment_loader

Overview:
- Sits between the host pipe-in endpoint (16-bit words, ti_clk domain) and the write side of the clock-segment FIFO.
- Assembles eight pipe words into one 128-bit segment record: on_counts[127:80], off_counts[79:32], repeat_counts[31:0].
- Validates each record and schedules its FIFO write, holding it while the FIFO is full.
- Keeps load statistics (segments written, expected output edges, errors) for host polling, and exposes a flush control so a new sequence can be loaded cleanly after an abort.

Parameters:
- DATA_W, 16, pipe word width.
- WORDS_PER_SEG, 8, pipe words per segment record.
- SEG_W, 128, record width; must equal DATA_W*WORDS_PER_SEG.
- CNT_W, 16, width of the segment, drop and invalid counters.

Ports:
- ti_clk, in, 1, sole clock (host interface clock).
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, single-cycle pulse; discards partial and pending data and clears statistics.
- pipe_write, in, 1, pipe word strobe.
- pipe_data, in, DATA_W, pipe word.
- fifo_full, in, 1, segment FIFO full flag.
- fifo_din, out, SEG_W, record to FIFO.
- fifo_wr_en, out, 1, FIFO write strobe, one cycle per record.
- seg_count, out, CNT_W, records written to the FIFO.
- expected_edges, out, 32, saturating sum of repeat_counts over written non-retrigger records.
- drop_count, out, CNT_W, records lost to overflow.
- invalid_count, out, CNT_W, records rejected by validation.
- overflow, out, 1, sticky: at least one record dropped.
- partial, out, 1, high while 1..7 words of a record are buffered.
- busy, out, 1, partial OR pending.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, word_idx=0, pending=0, shift register 0.
- Assembly:
  - Each pipe_write shifts pipe_data into a SEG_W shift register. The first word lands in [127:112], the eighth in [15:0] (MSB-first).
  - word_idx increments 0..7 and wraps to 0 on the eighth word; partial = (word_idx != 0).
- Completion (eighth word, cycle N): the record is validated combinationally from the shifted value and registered at N+1.
- Validation, with rep = repeat_counts:
  - rep == 0: retrigger record, always valid. on_counts is the timeout (0 = none); off_counts is ignored.
  - rep != 0: invalid if on_counts == 0 or off_counts == 0. An invalid record is not written, invalid_count +1 (saturating).
- Pending register, one entry. FSM states:
  - P_EMPTY: a valid record entering at N+1 goes to P_WRITE if fifo_full=0 at N+1, else to P_WAIT.
  - P_WRITE: fifo_wr_en=1 with fifo_din=record for exactly one cycle (N+1 for an unblocked write, i.e. latency 1 cycle from the 8th word). seg_count +1. If rep != 0, expected_edges += rep, saturating at 32'hFFFFFFFF. Next state is P_EMPTY, or P_WRITE directly if another record completes in the same cycle and fifo_full=0.
  - P_WAIT: hold the record. fifo_wr_en=0. Move to P_WRITE the cycle after fifo_full samples 0.
- Overflow: a record completing while in P_WAIT is dropped. drop_count +1 (saturating), overflow=1 (sticky until flush or reset). The pending record is kept. Assembly of further words continues unaffected.
- pipe_write and a FIFO write in the same cycle: both proceed; there is no pipe backpressure.
- flush (synchronous pulse):
  - Next cycle: word_idx=0, pending dropped, state P_EMPTY, all counters and overflow cleared, fifo_wr_en=0.
  - A pipe_write in the flush cycle is discarded.
  - flush has priority over every other event in that cycle.
- Reset mid-record or mid-wait: everything is discarded and no FIFO write is issued.
- All counters saturate; none wraps.

Decomposition:
- Shared package:
  - Field bit positions: ON_MSB=127, ON_LSB=80, OFF_MSB=79, OFF_LSB=32, REP_MSB=31, REP_LSB=0.
  - Defaults for WORDS_PER_SEG and SEG_W.
  - Pending FSM state encodings P_EMPTY=0, P_WRITE=1, P_WAIT=2.
  - The clock-generator FSM reuses the same field constants.
- One natural sub-module, seg_validate: purely combinational record checker producing is_retrigger and is_valid.
- Assembly, FSM and counters stay in segment_loader.

Test Plan:
- Basic record: 8 words 0x0000,0x0000,0x0005 / 0x0000,0x0000,0x0003 / 0x0000,0x000A, fifo_full=0 -> fifo_wr_en one cycle after the 8th word; fifo_din on=5, off=3, rep=10; seg_count=1; expected_edges=10.
- Retrigger record: on=1000, off=0, rep=0 -> written; seg_count increments; expected_edges unchanged; invalid_count=0.
- Invalid record: on=0, off=4, rep=2 -> no fifo_wr_en; invalid_count=1; partial=0 afterwards.
- Backpressure and overflow:
  - Hold fifo_full=1 and send two valid records -> first held (busy=1), second dropped; drop_count=1, overflow=1.
  - Release fifo_full -> exactly one write, carrying the first record.
- Flush mid-record: send 3 words then flush -> partial=0, busy=0, all counters 0.
  - Then send a full valid record -> written correctly, proving the word alignment was reset.
- Saturation: two records with rep=0xFFFFFFF0 each -> expected_edges=0xFFFFFFFF.
